// File: rtl/serial_alu_if.sv
// Handshake and operand/result bundle between an issuing stage and serial_alu_unit.
// The master drives requests and operands; the slave returns status, result and flags.
interface serial_alu_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             ready;
  logic [3:0]       op;
  logic             narrow;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_c;
  logic             flag_v;
  logic             flag_s;
  logic             flag_z;

  modport master (
    output start, op, narrow, a, b,
    input  ready, done, result, flag_c, flag_v, flag_s, flag_z
  );

  modport slave (
    input  start, op, narrow, a, b,
    output ready, done, result, flag_c, flag_v, flag_s, flag_z
  );
endinterface

// File: rtl/serial_alu_unit.sv
// Digit-serial ALU: NSHIFT bits per cycle LSB-first for arith/logic, one bit per cycle for shifts.
// Owns the C/V/S/Z flags; result and flags move only on the edge that raises done.
module serial_alu_unit #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NSHIFT = 2
) (
  input logic         clk,
  input logic         reset_n,
  serial_alu_if.slave bus
);
  localparam int unsigned Half   = WIDTH / 2;
  localparam int unsigned CntW   = $clog2(WIDTH + 1);
  localparam int unsigned KwFull = $clog2(WIDTH);
  localparam int unsigned KwHalf = $clog2(Half);

  localparam logic [CntW-1:0]  LastFull  = CntW'(WIDTH / NSHIFT - 1);
  localparam logic [CntW-1:0]  LastHalf  = CntW'(Half / NSHIFT - 1);
  localparam logic [WIDTH-1:0] FullMask  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] LoMask    = {{(WIDTH - Half){1'b0}}, {Half{1'b1}}};
  localparam logic [WIDTH-1:0] FullMsb   = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [WIDTH-1:0] HalfMsb   = LoMask ^ (LoMask >> 1);
  localparam logic [WIDTH-1:0] KMaskFull = WIDTH'((32'd1 << KwFull) - 32'd1);
  localparam logic [WIDTH-1:0] KMaskHalf = WIDTH'((32'd1 << KwHalf) - 32'd1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  typedef enum logic [3:0] {
    OpAdd = 4'd0, OpSub = 4'd1, OpAdc = 4'd2, OpSbc = 4'd3,
    OpAnd = 4'd4, OpOr  = 4'd5, OpXor = 4'd6, OpMov = 4'd7,
    OpCmp = 4'd8, OpShl = 4'd9, OpShr = 4'd10, OpSar = 4'd11
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             narrow_q, narrow_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             invb_q, invb_d;
  logic             zacc_q, zacc_d;
  logic             kzero_q, kzero_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             fc_q, fc_d, fv_q, fv_d, fs_q, fs_d, fz_q, fz_d;

  op_e              op_in;
  logic             in_shift, is_shift, is_arith;
  int unsigned      kval;
  logic [NSHIFT-1:0] da, db, dr;
  logic             c, c_top, msb_bit, shift_out;
  logic [WIDTH-1:0] msb_mask;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    narrow_d = narrow_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    invb_d   = invb_q;
    zacc_d   = zacc_q;
    kzero_d  = kzero_q;
    done_d   = 1'b0;
    result_d = result_q;
    fc_d     = fc_q;
    fv_d     = fv_q;
    fs_d     = fs_q;
    fz_d     = fz_q;

    op_in     = (bus.op > 4'd11) ? OpMov : op_e'(bus.op);
    in_shift  = (op_in == OpShl) || (op_in == OpShr) || (op_in == OpSar);
    is_shift  = (op_q == OpShl) || (op_q == OpShr) || (op_q == OpSar);
    is_arith  = (op_q == OpAdd) || (op_q == OpSub) || (op_q == OpAdc) ||
                (op_q == OpSbc) || (op_q == OpCmp);
    kval      = bus.narrow ? (32'(bus.b & KMaskHalf) % Half) : (32'(bus.b & KMaskFull) % WIDTH);
    msb_bit   = narrow_q ? opa_q[Half-1] : opa_q[WIDTH-1];
    msb_mask  = narrow_q ? HalfMsb : FullMsb;
    da        = NSHIFT'(opa_q >> (32'(cnt_q) * NSHIFT));
    db        = NSHIFT'(opb_q >> (32'(cnt_q) * NSHIFT));
    dr        = '0;
    c         = carry_q;
    c_top     = carry_q;
    shift_out = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StRun;
          op_d     = op_in;
          narrow_d = bus.narrow;
          opa_d    = bus.narrow ? (bus.a & LoMask) : bus.a;
          opb_d    = bus.narrow ? (bus.b & LoMask) : bus.b;
          acc_d    = '0;
          zacc_d   = 1'b1;
          invb_d   = (op_in == OpSub) || (op_in == OpSbc) || (op_in == OpCmp);
          unique case (op_in)
            OpSub, OpCmp: carry_d = 1'b1;
            OpAdc, OpSbc: carry_d = fc_q;
            default:      carry_d = 1'b0;
          endcase
          // Shifts count down remaining steps; digit ops count digits up from zero.
          if (in_shift) begin
            kzero_d = (kval == 0);
            cnt_d   = (kval == 0) ? CntW'(1) : CntW'(kval);
          end else begin
            kzero_d = 1'b0;
            cnt_d   = '0;
          end
        end
      end

      StRun: begin
        if (is_shift) begin
          if (!kzero_q) begin
            unique case (op_q)
              OpShl: begin
                shift_out = msb_bit;
                opa_d     = (opa_q << 1) & (narrow_q ? LoMask : FullMask);
              end
              OpShr: begin
                shift_out = opa_q[0];
                opa_d     = opa_q >> 1;
              end
              default: begin
                shift_out = opa_q[0];
                opa_d     = (opa_q >> 1) | (msb_bit ? msb_mask : '0);
              end
            endcase
            carry_d = shift_out;
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            state_d  = StIdle;
            done_d   = 1'b1;
            result_d = opa_d;
            fs_d     = narrow_q ? opa_d[Half-1] : opa_d[WIDTH-1];
            fz_d     = (opa_d == '0);
            if (!kzero_q) fc_d = shift_out;
          end
        end else begin
          if (invb_q) db = ~db;
          for (int i = 0; i < NSHIFT; i++) begin
            c_top = c;
            dr[i] = da[i] ^ db[i] ^ c;
            c     = (da[i] & db[i]) | (c & (da[i] ^ db[i]));
          end
          unique case (op_q)
            OpAnd:   dr = da & db;
            OpOr:    dr = da | db;
            OpXor:   dr = da ^ db;
            OpMov:   dr = da;
            default: ;
          endcase
          acc_d   = acc_q | (WIDTH'(dr) << (32'(cnt_q) * NSHIFT));
          zacc_d  = zacc_q & (dr == '0);
          carry_d = c;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == (narrow_q ? LastHalf : LastFull)) begin
            state_d = StIdle;
            done_d  = 1'b1;
            if (op_q != OpCmp) result_d = acc_d;
            fs_d = narrow_q ? acc_d[Half-1] : acc_d[WIDTH-1];
            fz_d = zacc_d;
            if (is_arith) begin
              fc_d = c;
              fv_d = c ^ c_top;
            end
          end
        end
      end

      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      narrow_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      invb_q   <= 1'b0;
      zacc_q   <= 1'b0;
      kzero_q  <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      result_q <= '0;
      fc_q     <= 1'b0;
      fv_q     <= 1'b0;
      fs_q     <= 1'b0;
      fz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      narrow_q <= narrow_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      invb_q   <= invb_d;
      zacc_q   <= zacc_d;
      kzero_q  <= kzero_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      result_q <= result_d;
      fc_q     <= fc_d;
      fv_q     <= fv_d;
      fs_q     <= fs_d;
      fz_q     <= fz_d;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flag_c = fc_q;
  assign bus.flag_v = fv_q;
  assign bus.flag_s = fs_q;
  assign bus.flag_z = fz_q;

endmodule

// File: tb/tb_serial_alu_unit.sv
// Bench for serial_alu_unit (WIDTH=16, NSHIFT=2): directed vectors, reset abort, then random ops
// checked against an arithmetic reference model.
module tb_serial_alu_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [15:0] m_res;
  bit          m_c, m_v, m_s, m_z;

  serial_alu_if #(.WIDTH(16)) bus ();

  serial_alu_unit #(.WIDTH(16), .NSHIFT(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the active width.
  task automatic model_op(input logic [3:0] opr, input bit nr, input logic [15:0] a,
                          input logic [15:0] b, output int cyc);
    int unsigned w, msk, aa, bb, be, sum, r;
    int          sa, k, o;
    bit          cin, sub;
    w   = nr ? 8 : 16;
    msk = (1 << w) - 1;
    aa  = a & msk;
    bb  = b & msk;
    o   = (opr > 11) ? 7 : int'(opr);
    if (o <= 3 || o == 8) begin
      sub  = (o == 1 || o == 3 || o == 8);
      be   = sub ? (~bb & msk) : bb;
      cin  = (o == 0) ? 1'b0 : (o == 1 || o == 8) ? 1'b1 : m_c;
      sum  = aa + be + cin;
      r    = sum & msk;
      m_c  = ((sum >> w) & 1) != 0;
      m_v  = (((aa >> (w-1)) & 1) == ((be >> (w-1)) & 1)) &&
             (((r >> (w-1)) & 1) != ((aa >> (w-1)) & 1));
      m_s  = ((r >> (w-1)) & 1) != 0;
      m_z  = (r == 0);
      if (o != 8) m_res = 16'(r);
      cyc  = w / 2;
    end else if (o <= 7) begin
      case (o)
        4:       r = aa & bb;
        5:       r = aa | bb;
        6:       r = aa ^ bb;
        default: r = aa;
      endcase
      m_s   = ((r >> (w-1)) & 1) != 0;
      m_z   = (r == 0);
      m_res = 16'(r);
      cyc   = w / 2;
    end else begin
      k = int'(b & (nr ? 16'd7 : 16'd15)) % int'(w);
      if (o == 9) begin
        r = (aa << k) & msk;
        if (k > 0) m_c = ((aa >> (w - k)) & 1) != 0;
      end else if (o == 10) begin
        r = aa >> k;
        if (k > 0) m_c = ((aa >> (k - 1)) & 1) != 0;
      end else begin
        sa = ((aa >> (w-1)) & 1) != 0 ? int'(aa | ~msk) : int'(aa);
        r  = int'(sa >>> k) & msk;
        if (k > 0) m_c = ((sa >>> (k - 1)) & 1) != 0;
      end
      m_s   = ((r >> (w-1)) & 1) != 0;
      m_z   = (r == 0);
      m_res = 16'(r);
      cyc   = (k == 0) ? 1 : k;
    end
  endtask

  // Called at a negedge; issues one op, scrambles inputs while busy, returns in the done cycle.
  task automatic do_op(input logic [3:0] opr, input bit nr, input logic [15:0] a,
                       input logic [15:0] b);
    int          exp_cyc, cyc;
    logic [15:0] res0;
    logic [3:0]  flg0;
    bit          changed;
    res0 = bus.result;
    flg0 = {bus.flag_c, bus.flag_v, bus.flag_s, bus.flag_z};
    model_op(opr, nr, a, b, exp_cyc);
    check_eq("ready_idle", bus.ready, 1);
    bus.start  = 1'b1;
    bus.op     = opr;
    bus.narrow = nr;
    bus.a      = a;
    bus.b      = b;
    @(negedge clk);
    cyc     = 0;
    changed = 1'b0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (bus.ready !== 1'b0) changed = 1'b1;
      bus.start  = 1'($urandom_range(0, 1));
      bus.op     = 4'($urandom);
      bus.narrow = 1'($urandom);
      bus.a      = 16'($urandom);
      bus.b      = 16'($urandom);
      @(negedge clk);
      cyc++;
      if (bus.done !== 1'b1 &&
          (bus.result !== res0 || {bus.flag_c, bus.flag_v, bus.flag_s, bus.flag_z} !== flg0))
        changed = 1'b1;
    end
    bus.start = 1'b0;
    check_eq("cycles", cyc, exp_cyc);
    check_eq("busy_stable", changed, 0);
    check_eq("result", bus.result, m_res);
    check_eq("flags_cvsz", {bus.flag_c, bus.flag_v, bus.flag_s, bus.flag_z},
             {m_c, m_v, m_s, m_z});
  endtask

  initial begin
    m_res = '0;
    {m_c, m_v, m_s, m_z} = '0;
    bus.start = 1'b0; bus.op = '0; bus.narrow = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", bus.ready, 1);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_result", bus.result, 0);
    check_eq("rst_flags", {bus.flag_c, bus.flag_v, bus.flag_s, bus.flag_z}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    do_op(4'd0, 1'b0, 16'h7FFF, 16'h0001);
    check_eq("add_vec", {bus.result, bus.flag_c, bus.flag_v, bus.flag_s, bus.flag_z},
             {16'h8000, 4'b0110});
    do_op(4'd1, 1'b0, 16'h0000, 16'h0001);
    check_eq("sub_vec", {bus.result, bus.flag_c, bus.flag_s}, {16'hFFFF, 2'b01});
    do_op(4'd3, 1'b0, 16'h0005, 16'h0002);
    check_eq("sbc_vec", {bus.result, bus.flag_c, bus.flag_z}, {16'h0002, 2'b10});
    do_op(4'd8, 1'b0, 16'h1234, 16'h1234);
    check_eq("cmp_vec", {bus.result, bus.flag_c, bus.flag_v, bus.flag_s, bus.flag_z},
             {16'h0002, 4'b1001});
    do_op(4'd0, 1'b1, 16'hAB80, 16'hCD80);
    check_eq("narrow_vec", {bus.result, bus.flag_c, bus.flag_v, bus.flag_s, bus.flag_z},
             {16'h0000, 4'b1101});
    do_op(4'd10, 1'b0, 16'h0006, 16'h0002);
    check_eq("shr_vec", {bus.result, bus.flag_c}, {16'h0001, 1'b1});
    do_op(4'd11, 1'b0, 16'h8001, 16'h0003);
    check_eq("sar_vec", {bus.result, bus.flag_c}, {16'hF000, 1'b0});
    do_op(4'd9, 1'b0, 16'h1234, 16'h0010);
    check_eq("shl0_vec", {bus.result, bus.flag_c}, {16'h1234, 1'b0});
    do_op(4'd2, 1'b0, 16'hFFFF, 16'h0001);
    do_op(4'd2, 1'b0, 16'h0001, 16'h0001);
    do_op(4'd13, 1'b1, 16'hFF85, 16'h0000);
    do_op(4'd9, 1'b1, 16'h00C1, 16'h00F9);
    do_op(4'd6, 1'b0, 16'h5A5A, 16'h5A5A);

    // Abort an ADD on its fourth busy cycle.
    bus.start = 1'b1; bus.op = 4'd0; bus.narrow = 1'b0; bus.a = 16'h1111; bus.b = 16'h2222;
    @(negedge clk);
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    reset_n = 1'b0;
    #1;
    check_eq("abort_ready", bus.ready, 1);
    check_eq("abort_done", bus.done, 0);
    check_eq("abort_result", bus.result, 0);
    check_eq("abort_flags", {bus.flag_c, bus.flag_v, bus.flag_s, bus.flag_z}, 0);
    m_res = '0;
    {m_c, m_v, m_s, m_z} = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("abort_no_done", bus.done, 0);

    for (int i = 0; i < 200; i++) begin
      do_op(4'($urandom_range(0, 15)), 1'($urandom), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        check_eq("done_pulse", bus.done, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
